sync_bus_settle_rx: RTL and testbench
=====================================

// Module: sync_bus_settle_rx
// PURPOSE
// - Destination-side consumer of a multi-bit synchronizer output, such as a 2-flop-per-bit array carrying a quasi-static bus.
// - Per-bit synchronizers can present mixed old/new bits for a few cycles, so the raw bus is not a valid word.
// - This block waits until the synchronized bus has been stable for STABLE_CYCLES consecutive clocks.
// - It then publishes the word as a coherent value with a one-cycle update strobe, and flags buses that never settle.
// PARAMETERS
// - BUS_WIDTH      2   width of the transferred bus
// - STABLE_CYCLES  3   consecutive equal samples required before accepting (>=1)
// - MAX_SETTLE     64  settle cycles before unstable_err is raised (>STABLE_CYCLES)
// PORTS
// - clk           in   1          destination clock; all logic on its rising edge
// - rst           in   1          asynchronous, active-high reset
// - data_in       in   BUS_WIDTH  synchronized but possibly incoherent bus
// - err_clr       in   1          clears sticky unstable_err
// - data_out      out  BUS_WIDTH  last accepted coherent word
// - data_valid    out  1          one-cycle pulse when data_out takes a new value
// - settling      out  1          high while state==SETTLE
// - unstable_err  out  1          sticky: bus failed to settle within MAX_SETTLE cycles
// - gray_err      out  1          one-cycle pulse (GRAY_CHECK_EN only; tied 0 otherwise)
// BEHAVIOUR
// - Reset, asynchronous: all outputs and internal registers are 0, and state=STABLE.
// - Internal registers:
//   - sample_reg[BUS_WIDTH] holds the candidate word.
//   - stab_cnt has width $clog2(STABLE_CYCLES+1).
//   - settle_cnt has width $clog2(MAX_SETTLE+1); it saturates at MAX_SETTLE and never wraps.
// - STABLE state:
//   - If data_in==data_out, hold.
//   - If data_in!=data_out: sample_reg<=data_in, stab_cnt<=0, settle_cnt<=1, go to SETTLE.
// - SETTLE state, evaluated each edge in this priority order:
//   1. data_in!=sample_reg: sample_reg<=data_in, stab_cnt<=0. settle_cnt still increments; it is not reset by re-changes.
//   2. data_in==sample_reg and stab_cnt==STABLE_CYCLES-1, with sample_reg!=data_out: data_out<=sample_reg, data_valid<=1, go to STABLE.
//   3. data_in==sample_reg and stab_cnt==STABLE_CYCLES-1, with sample_reg==data_out (glitch returned to old value): go to STABLE, no data_valid.
//   4. Otherwise: stab_cnt<=stab_cnt+1.
// - Latency: a new value applied before edge k and held is accepted at edge k+STABLE_CYCLES. data_valid is high in the following cycle only.
// - data_valid is registered and is high for exactly one cycle per accepted change. It never asserts on consecutive cycles.
// - unstable_err:
//   - Set on the edge where settle_cnt reaches MAX_SETTLE while still in SETTLE.
//   - Cleared by err_clr. If set and clear occur on the same edge, set wins.
//   - Settling continues after the error; a later clean settle still updates data_out.
// - Reset mid-SETTLE: the pending candidate is discarded and data_out returns to 0.
// - data_in is treated as already synchronized. There is no internal metastability flop.
// CONFIGURATION
// - GRAY_CHECK_EN defined:
//   - On acceptance, if popcount(sample_reg ^ data_out)!=1, gray_err pulses for 1 cycle, coincident with data_valid.
//   - data_out is still updated.
//   - Intended for gray-coded pointer or counter transfer.
// - GRAY_CHECK_EN undefined: gray_err is constant 0 and no XOR/popcount logic is built.
// TESTING
// - Reset: assert rst asynchronously mid-cycle. Required: data_out=0, data_valid=0, settling=0, unstable_err=0 immediately, without waiting for clk.
// - Clean change (BUS_WIDTH=2, STABLE_CYCLES=3): data_in 00->11 before edge 0 and held. Required: data_out=11 after edge 3, data_valid high 1 cycle, settling high edges 0-3.
// - Skewed bits: data_in 00->01 (edge 0), then ->11 (edge 1), held. Required: data_out=11 after edge 4, one data_valid pulse, 01 never visible.
// - Glitch: data_in 00->10 for 1 cycle then back to 00. Required: data_out stays 00, no data_valid, settling drops after STABLE_CYCLES compares.
// - Toggle data_in every cycle for 70 cycles (MAX_SETTLE=64).
//   - Required: unstable_err set 64 cycles after the first change.
//   - err_clr with data_in still toggling: error stays set (set wins).
//   - Hold data_in, then err_clr: error clears and data_out updates normally.
// - GRAY_CHECK_EN: accept 00->01, then 01->10.
//   - Required: no gray_err on the first acceptance.
//   - gray_err pulses with data_valid on the second acceptance; data_out=10.

Source files
------------

// File: rtl/sync_bus_settle_rx.sv
// Accepts a per-bit-synchronized bus only after it has held one value for STABLE_CYCLES clocks.
// Optional macro GRAY_CHECK_EN adds a single-bit-change check on each accepted word.
module sync_bus_settle_rx #(
    parameter int unsigned BUS_WIDTH     = 2,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned MAX_SETTLE    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 err_clr,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 settling,
    output logic                 unstable_err,
    output logic                 gray_err
);

    localparam int unsigned STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(MAX_SETTLE + 1);
    localparam logic [STAB_W-1:0]   STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(MAX_SETTLE);

    typedef enum logic {StStable, StSettle} state_t;

    state_t                state_q, state_d;
    logic [BUS_WIDTH-1:0]  sample_q, sample_d;
    logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [SETTLE_W-1:0]   settle_inc;
    logic [BUS_WIDTH-1:0]  data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  unstable_err_q, unstable_err_d;
`ifdef GRAY_CHECK_EN
    logic                  gray_err_q, gray_err_d;
`endif

    // Settle time saturates so a bus that never settles keeps the error asserted.
    assign settle_inc = (settle_cnt_q == SETTLE_MAX) ? settle_cnt_q
                                                     : settle_cnt_q + SETTLE_W'(1);

    always_comb begin
        state_d        = state_q;
        sample_d       = sample_q;
        stab_cnt_d     = stab_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        unstable_err_d = unstable_err_q & ~err_clr;
`ifdef GRAY_CHECK_EN
        gray_err_d     = 1'b0;
`endif
        unique case (state_q)
            StStable: begin
                if (data_in != data_out_q) begin
                    sample_d     = data_in;
                    stab_cnt_d   = '0;
                    settle_cnt_d = SETTLE_W'(1);
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                settle_cnt_d = settle_inc;
                if (settle_inc == SETTLE_MAX) begin
                    unstable_err_d = 1'b1;
                end
                if (data_in != sample_q) begin
                    sample_d   = data_in;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = StStable;
                    // A glitch that returned to the old word settles silently.
                    if (sample_q != data_out_q) begin
                        data_out_d   = sample_q;
                        data_valid_d = 1'b1;
`ifdef GRAY_CHECK_EN
                        gray_err_d   = ($countones(sample_q ^ data_out_q) != 1);
`endif
                    end
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            default: state_d = StStable;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StStable;
            sample_q       <= '0;
            stab_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            unstable_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_q       <= sample_d;
            stab_cnt_q     <= stab_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            unstable_err_q <= unstable_err_d;
        end
    end

`ifdef GRAY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_err_q <= 1'b0;
        end else begin
            gray_err_q <= gray_err_d;
        end
    end
    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign settling     = (state_q == StSettle);
    assign unstable_err = unstable_err_q;

endmodule

// File: tb/tb_sync_bus_settle_rx.sv
// Bench for sync_bus_settle_rx: directed scenarios plus random holds checked against a
// run-length reference model.
module tb_sync_bus_settle_rx;

    localparam int BW = 2;
    localparam int SC = 3;
    localparam int MS = 64;

    logic          clk;
    logic          rst;
    logic [BW-1:0] data_in;
    logic          err_clr;
    logic [BW-1:0] data_out;
    logic          data_valid;
    logic          settling;
    logic          unstable_err;
    logic          gray_err;

    int checks = 0;
    int errors = 0;

    // Reference model: candidate word, run length of identical samples, settle time.
    logic [BW-1:0] m_out;
    logic [BW-1:0] m_cand;
    logic          m_valid, m_settling, m_err, m_gray;
    int            m_run, m_settle_t;

    int vcount, gcount, first_err;
    logic seen01;

    sync_bus_settle_rx #(
        .BUS_WIDTH    (BW),
        .STABLE_CYCLES(SC),
        .MAX_SETTLE   (MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .settling    (settling),
        .unstable_err(unstable_err),
        .gray_err    (gray_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_cand = '0; m_valid = 1'b0; m_settling = 1'b0;
        m_err = 1'b0; m_gray = 1'b0; m_run = 0; m_settle_t = 0;
    endtask

    task automatic model_step(input logic [BW-1:0] d, input logic clr);
        logic err_set;
        err_set = 1'b0;
        m_valid = 1'b0;
        m_gray  = 1'b0;
        if (!m_settling) begin
            if (d != m_out) begin
                m_settling = 1'b1;
                m_cand     = d;
                m_run      = 1;
                m_settle_t = 1;
            end
        end else begin
            m_settle_t = (m_settle_t < MS) ? m_settle_t + 1 : MS;
            if (m_settle_t == MS) err_set = 1'b1;
            if (d != m_cand) begin
                m_cand = d;
                m_run  = 1;
            end else begin
                m_run++;
                // First sample plus SC identical re-samples completes the settle.
                if (m_run == SC + 1) begin
                    m_settling = 1'b0;
                    if (m_cand != m_out) begin
                        m_valid = 1'b1;
`ifdef GRAY_CHECK_EN
                        m_gray = ($countones(m_cand ^ m_out) != 1);
`endif
                        m_out = m_cand;
                    end
                end
            end
        end
        m_err = err_set | (m_err & ~clr);
    endtask

    task automatic compare_all();
        check("data_out", 32'(data_out), 32'(m_out));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("settling", 32'(settling), 32'(m_settling));
        check("unstable_err", 32'(unstable_err), 32'(m_err));
        check("gray_err", 32'(gray_err), 32'(m_gray));
    endtask

    // Drive at posedge+1, capture on the next edge, compare at posedge+1.
    task automatic tick(input logic [BW-1:0] d, input logic clr);
        data_in = d;
        err_clr = clr;
        @(posedge clk);
        model_step(d, clr);
        #1;
        compare_all();
        if (data_valid) vcount++;
        if (gray_err) gcount++;
        if (data_out == 2'b01) seen01 = 1'b1;
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_settling", 32'(settling), 32'h0);
        check("rst_unstable_err", 32'(unstable_err), 32'h0);
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [BW-1:0] d;
        int hold;
        rst = 1'b1;
        data_in = '0;
        err_clr = 1'b0;
        model_reset();
        #1;
        check("init_data_out", 32'(data_out), 32'h0);
        check("init_settling", 32'(settling), 32'h0);
        #11 rst = 1'b0;

        // Clean change 00 -> 11.
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick(2'b11, 1'b0);
            if (i == 2) check("clean_not_yet", 32'(data_out), 32'h0);
            if (i == 3) check("clean_accept", 32'(data_out), 32'h3);
        end
        check("clean_pulses", 32'(vcount), 32'h1);

        // Skewed bits 00 -> 01 -> 11.
        async_reset();
        vcount = 0;
        seen01 = 1'b0;
        tick(2'b01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(2'b11, 1'b0);
            if (i == 2) check("skew_not_yet", 32'(data_out), 32'h0);
            if (i == 3) check("skew_accept", 32'(data_out), 32'h3);
        end
        check("skew_pulses", 32'(vcount), 32'h1);
        check("skew_no01", 32'(seen01), 32'h0);

        // One-cycle glitch back to the old word.
        async_reset();
        vcount = 0;
        tick(2'b10, 1'b0);
        for (int i = 0; i < 6; i++) tick(2'b00, 1'b0);
        check("glitch_out", 32'(data_out), 32'h0);
        check("glitch_pulses", 32'(vcount), 32'h0);
        check("glitch_settled", 32'(settling), 32'h0);

        // Toggle every cycle until the settle budget is exhausted.
        d = 2'b00;
        first_err = -1;
        for (int i = 0; i < 70; i++) begin
            d = ~d;
            tick(d, (i == 66));
            if (unstable_err && first_err < 0) first_err = i;
        end
        check("err_edge", 32'(first_err), 32'd63);
        check("err_set_wins", 32'(unstable_err), 32'h1);
        vcount = 0;
        for (int i = 0; i < 6; i++) tick(2'b11, 1'b0);
        check("post_err_out", 32'(data_out), 32'h3);
        check("post_err_pulses", 32'(vcount), 32'h1);
        tick(2'b11, 1'b1);
        check("err_cleared", 32'(unstable_err), 32'h0);

        // Reset while a candidate is pending.
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        check("pending_settling", 32'(settling), 32'h1);
        async_reset();
        tick(2'b00, 1'b0);
        check("pending_dropped", 32'(data_out), 32'h0);

`ifdef GRAY_CHECK_EN
        gcount = 0;
        for (int i = 0; i < 5; i++) tick(2'b01, 1'b0);
        check("gray_first", 32'(gcount), 32'h0);
        for (int i = 0; i < 5; i++) tick(2'b10, 1'b0);
        check("gray_second", 32'(gcount), 32'h1);
        check("gray_out", 32'(data_out), 32'h2);
`endif

        // Random words with random hold lengths and occasional clears.
        for (int n = 0; n < 120; n++) begin
            d = BW'($urandom_range(0, (1 << BW) - 1));
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) tick(d, ($urandom_range(0, 7) == 0));
        end

        async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
